operand_entry: RTL and testbench
================================

# operand_entry

Keypad-to-ALU sequencer directly upstream of the two-digit signed BCD ALU. Collects decimal digits, sign toggles and operator keys from a pre-debounced keypad and builds 9-bit sign-magnitude BCD operands. Drives the ALU's `op`, `opcode`, `assign_op1`, `assign_op2` and `alu_en` with the timing that the ALU's registered capture path needs. Also selects the value shown on the display.

## Interface
- `WAIT_CYC`, default 2: cycles `op` is held stable after an assign pulse; must be ≥2.
- `clk`, in, 1: clock.
- `nrst`, in, 1: reset, asynchronous, active-low.
- `key_valid`, in, 1: one-cycle strobe, already synchronized and debounced.
- `key_code`, in, 5: 0–9 digit, 10 add, 11 sub, 12 equals, 13 clear, 14 negate; 15–31 ignored.
- `result`, in, 9: ALU result `{sign, tens, ones}`.
- `o_flag`, in, 1: ALU overflow.
- `op`, out, 9: operand `{sign, tens BCD, ones BCD}` to ALU.
- `opcode`, out, 3: ADD=3'b001, SUB=3'b010.
- `assign_op1`, out, 1: one-cycle pulse.
- `assign_op2`, out, 1: one-cycle pulse.
- `alu_en`, out, 1: ALU result valid request.
- `disp_val`, out, 9: value to display.
- `disp_err`, out, 1: overflow indication.

## Operation
- FSM states: OP1, LOAD1, OP2, LOAD2, RESULT.
- Entry register (9 bits):
  - A digit shifts it: tens←ones, ones←digit. The sign is kept. A third digit discards the oldest tens digit.
  - Negate toggles bit 8.
- OP1:
  - Digits and negate edit the entry.
  - Add/sub stores `opcode`, pulses `assign_op1` with `op` = entry, then goes to LOAD1.
  - Equals is ignored.
- LOAD1:
  - Holds `op` for WAIT_CYC cycles.
  - Then clears the entry to 0 and goes to OP2.
- OP2:
  - Digits and negate edit the entry.
  - Equals pulses `assign_op2` and goes to LOAD2.
  - Add/sub is ignored.
- LOAD2: holds `op` for WAIT_CYC cycles, then goes to RESULT.
- RESULT:
  - `alu_en`=1.
  - A digit clears the entry, loads that digit as ones, and goes to OP1.
  - Negate and equals are ignored.
  - Add/sub: see Configuration.
- Clear, in any state:
  - Entry=0, `opcode`=ADD, `alu_en`=0, go to OP1.
  - A pending LOAD wait is abandoned.
- Keys arriving in LOAD1/LOAD2 are dropped, except clear.
- `disp_val`: entry in OP1/OP2/LOAD*; `result` in RESULT.
- `disp_err` = `o_flag` & (state==RESULT).
- Magnitudes are always valid BCD, 0–99. Negative zero (9'h100) is passed through unchanged.

## Timing
- Reset values:
  - `op`=0, `opcode`=3'b001, `assign_op1`=`assign_op2`=0, `alu_en`=0, `disp_val`=0, `disp_err`=0.
  - State OP1.
- All outputs are registered except `disp_val` and `disp_err`, which are combinational from registered state and `result`.
- A key accepted at edge E takes effect at edge E+1:
  - The `assign` pulse is high for the cycle after E.
  - `op` is valid in that same cycle.
- The ALU registers the assign, then captures `op` one edge later. `op` must therefore be unchanged for the pulse cycle plus WAIT_CYC−1 following cycles.
- `opcode` changes only on an accepted operator key or clear, always ≥WAIT_CYC+1 cycles before `alu_en` rises.
- `alu_en` rises on the edge entering RESULT. It falls on the edge leaving RESULT.
- `key_valid` held high for several cycles counts as repeated keys; upstream guarantees one-cycle strobes.
- `nrst` asserted mid-sequence (including during an assign pulse) forces reset values immediately.

## Configuration
- `OPERAND_CHAIN_EN` defined, add/sub in RESULT:
  - If `o_flag`=0: loads `{result[8], result[7:0]}` into the entry, stores `opcode`, pulses `assign_op1`, and goes to LOAD1.
  - If `o_flag`=1: the key is ignored.
- Not defined: add/sub in RESULT is ignored.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OPC_ADD` and `OPC_SUB`.
  - Key-code constants `KEY_ADD`, `KEY_SUB`, `KEY_EQ`, `KEY_CLR`, `KEY_NEG`.
  - State enum `entry_state_t`.
- Sub-module `bcd_digit_reg`: 9-bit entry register with shift-in-digit, negate, clear and parallel load. The FSM and wait counter stay in the top module.

## Test plan
- Keys 4,7,add,1,2,eq:
  - `assign_op1` pulse with `op`=9'h047, `opcode`=001.
  - `assign_op2` pulse with `op`=9'h012.
  - `op` stable for 2 cycles after each pulse.
  - `alu_en`=1 afterwards.
- Keys 3,neg,sub,5,eq: `op`=9'h103 at `assign_op1`, `opcode`=010, `op`=9'h005 at `assign_op2`.
- Keys 1,2,3: `disp_val`=9'h023. Then neg,neg: `disp_val`=9'h023.
- Key 6 during LOAD1 is dropped: OP2 entry starts at 0. Clear during LOAD2: OP1, `alu_en` stays 0, `opcode`=001.
- With `OPERAND_CHAIN_EN`, in RESULT with `result`=9'h059, `o_flag`=0, key add: `assign_op1` pulse with `op`=9'h059. With `o_flag`=1 the key is ignored and `disp_err`=1.
- `nrst` low during the `assign_op2` pulse: all outputs return to reset values within the same cycle. State is OP1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the keypad-to-ALU operand entry path.
package alu_pkg;

  localparam int ENTRY_W = 9;

  localparam logic [2:0] OPC_ADD = 3'b001;
  localparam logic [2:0] OPC_SUB = 3'b010;

  localparam logic [4:0] KEY_ADD = 5'd10;
  localparam logic [4:0] KEY_SUB = 5'd11;
  localparam logic [4:0] KEY_EQ  = 5'd12;
  localparam logic [4:0] KEY_CLR = 5'd13;
  localparam logic [4:0] KEY_NEG = 5'd14;

  typedef enum logic [2:0] {
    ST_OP1    = 3'd0,
    ST_LOAD1  = 3'd1,
    ST_OP2    = 3'd2,
    ST_LOAD2  = 3'd3,
    ST_RESULT = 3'd4
  } entry_state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return (code <= 5'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_reg.sv
// 9-bit sign-magnitude BCD entry register: shift-in digit, negate, clear, parallel load.
module bcd_digit_reg
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic               neg_i,
  input  logic [3:0]         digit_i,
  input  logic [ENTRY_W-1:0] load_val_i,
  output logic [ENTRY_W-1:0] entry_o
);

  logic [ENTRY_W-1:0] entry_q;
  logic [ENTRY_W-1:0] entry_d;

  // Next entry value; clear beats load beats shift beats negate.
  always_comb begin
    entry_d = entry_q;
    if (clr_i) begin
      entry_d = '0;
    end else if (load_i) begin
      entry_d = load_val_i;
    end else if (shift_i) begin
      entry_d = {entry_q[8], entry_q[3:0], digit_i};
    end else if (neg_i) begin
      entry_d = {~entry_q[8], entry_q[7:0]};
    end else begin
      entry_d = entry_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/operand_entry.sv
// Keypad-to-ALU sequencer: builds BCD operands and drives the ALU assign/enable handshake.
// Define OPERAND_CHAIN_EN to let add/sub in RESULT reuse the result as the next first operand.
module operand_entry
  import alu_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic [8:0] result,
  input  logic       o_flag,
  output logic [8:0] op,
  output logic [2:0] opcode,
  output logic       assign_op1,
  output logic       assign_op2,
  output logic       alu_en,
  output logic [8:0] disp_val,
  output logic       disp_err
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  entry_state_t  state_q;
  logic [CW-1:0] wait_q;
  logic [8:0]    op_q;
  logic [2:0]    opcode_q;
  logic          assign_op1_q;
  logic          assign_op2_q;
  logic          alu_en_q;

  logic          key_digit_s;
  logic          key_op_s;
  logic          key_eq_s;
  logic          key_clr_s;
  logic          key_neg_s;
  logic          chain_ok_s;
  logic          load_done_s;
  logic [2:0]    key_opc_s;

  logic          ent_clr_s;
  logic          ent_load_s;
  logic          ent_shift_s;
  logic          ent_neg_s;
  logic [8:0]    ent_load_val_s;
  logic [8:0]    entry_s;

  // Key decode.
  always_comb begin
    key_digit_s = key_valid && is_digit(key_code);
    key_op_s    = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
    key_eq_s    = key_valid && (key_code == KEY_EQ);
    key_clr_s   = key_valid && (key_code == KEY_CLR);
    key_neg_s   = key_valid && (key_code == KEY_NEG);
    key_opc_s   = (key_code == KEY_SUB) ? OPC_SUB : OPC_ADD;
    load_done_s = (wait_q == '0);
`ifdef OPERAND_CHAIN_EN
    chain_ok_s  = (state_q == ST_RESULT) && key_op_s && !o_flag;
`else
    chain_ok_s  = 1'b0;
`endif
  end

  // Entry register control derived from state and key.
  always_comb begin
    ent_clr_s      = 1'b0;
    ent_load_s     = 1'b0;
    ent_shift_s    = 1'b0;
    ent_neg_s      = 1'b0;
    ent_load_val_s = '0;
    if (key_clr_s) begin
      ent_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_OP1, ST_OP2: begin
          ent_shift_s = key_digit_s;
          ent_neg_s   = key_neg_s;
        end
        ST_LOAD1: begin
          ent_clr_s = load_done_s;
        end
        ST_RESULT: begin
          if (key_digit_s) begin
            ent_load_s     = 1'b1;
            ent_load_val_s = {1'b0, 4'h0, key_code[3:0]};
          end else if (chain_ok_s) begin
            ent_load_s     = 1'b1;
            ent_load_val_s = result;
          end else begin
            ent_load_s     = 1'b0;
          end
        end
        default: begin
          ent_clr_s = 1'b0;
        end
      endcase
    end
  end

  bcd_digit_reg u_entry (
    .clk        (clk),
    .nrst       (nrst),
    .clr_i      (ent_clr_s),
    .load_i     (ent_load_s),
    .shift_i    (ent_shift_s),
    .neg_i      (ent_neg_s),
    .digit_i    (key_code[3:0]),
    .load_val_i (ent_load_val_s),
    .entry_o    (entry_s)
  );

  // Sequencer FSM with registered ALU-facing outputs; assign pulses self-clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_OP1;
      wait_q       <= '0;
      op_q         <= '0;
      opcode_q     <= OPC_ADD;
      assign_op1_q <= 1'b0;
      assign_op2_q <= 1'b0;
      alu_en_q     <= 1'b0;
    end else begin
      assign_op1_q <= 1'b0;
      assign_op2_q <= 1'b0;
      if (key_clr_s) begin
        state_q  <= ST_OP1;
        opcode_q <= OPC_ADD;
        alu_en_q <= 1'b0;
      end else begin
        case (state_q)
          ST_OP1: begin
            if (key_op_s) begin
              opcode_q     <= key_opc_s;
              op_q         <= entry_s;
              assign_op1_q <= 1'b1;
              wait_q       <= CW'(WAIT_CYC - 1);
              state_q      <= ST_LOAD1;
            end
          end
          ST_LOAD1: begin
            if (load_done_s) begin
              state_q <= ST_OP2;
            end else begin
              wait_q  <= wait_q - CW'(1);
            end
          end
          ST_OP2: begin
            if (key_eq_s) begin
              op_q         <= entry_s;
              assign_op2_q <= 1'b1;
              wait_q       <= CW'(WAIT_CYC - 1);
              state_q      <= ST_LOAD2;
            end
          end
          ST_LOAD2: begin
            if (load_done_s) begin
              state_q  <= ST_RESULT;
              alu_en_q <= 1'b1;
            end else begin
              wait_q   <= wait_q - CW'(1);
            end
          end
          ST_RESULT: begin
            if (key_digit_s) begin
              state_q  <= ST_OP1;
              alu_en_q <= 1'b0;
            end else if (chain_ok_s) begin
              opcode_q     <= key_opc_s;
              op_q         <= result;
              assign_op1_q <= 1'b1;
              wait_q       <= CW'(WAIT_CYC - 1);
              state_q      <= ST_LOAD1;
              alu_en_q     <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_OP1;
          end
        endcase
      end
    end
  end

  assign op         = op_q;
  assign opcode     = opcode_q;
  assign assign_op1 = assign_op1_q;
  assign assign_op2 = assign_op2_q;
  assign alu_en     = alu_en_q;
  assign disp_val   = (state_q == ST_RESULT) ? result : entry_s;
  assign disp_err   = o_flag && (state_q == ST_RESULT);

endmodule

// File: tb/tb_operand_entry.sv
// Randomised and directed bench for operand_entry against a decimal-arithmetic reference model.
module tb_operand_entry;

  localparam int WAIT_CYC = 2;

  logic       clk = 1'b0;
  logic       nrst;
  logic       key_valid;
  logic [4:0] key_code;
  logic [8:0] result;
  logic       o_flag;
  logic [8:0] op;
  logic [2:0] opcode;
  logic       assign_op1;
  logic       assign_op2;
  logic       alu_en;
  logic [8:0] disp_val;
  logic       disp_err;

  operand_entry #(.WAIT_CYC(WAIT_CYC)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .result     (result),
    .o_flag     (o_flag),
    .op         (op),
    .opcode     (opcode),
    .assign_op1 (assign_op1),
    .assign_op2 (assign_op2),
    .alu_en     (alu_en),
    .disp_val   (disp_val),
    .disp_err   (disp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase number, signed decimal entry, pending wait length.
  localparam int P_OP1 = 0, P_LOAD1 = 1, P_OP2 = 2, P_LOAD2 = 3, P_RES = 4;
  int         m_phase;
  bit         m_neg;
  int         m_mag;
  int         m_left;
  logic [8:0] m_op;
  logic [2:0] m_opcode;
  bit         m_a1, m_a2, m_en;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] to_bcd(input bit s, input int m);
    logic [3:0] t, o;
    t = 4'(m / 10);
    o = 4'(m % 10);
    return {s, t, o};
  endfunction

  task automatic model_reset();
    m_phase = P_OP1; m_neg = 1'b0; m_mag = 0; m_left = 0;
    m_op = 9'h000; m_opcode = 3'b001; m_a1 = 1'b0; m_a2 = 1'b0; m_en = 1'b0;
  endtask

  task automatic model_step(input bit kv, input logic [4:0] kc, input logic [8:0] res, input bit of);
    int k;
    bit chain;
    k = int'(kc);
`ifdef OPERAND_CHAIN_EN
    chain = 1'b1;
`else
    chain = 1'b0;
`endif
    m_a1 = 1'b0;
    m_a2 = 1'b0;
    if (kv && k == 13) begin
      m_mag = 0; m_neg = 1'b0; m_opcode = 3'b001; m_en = 1'b0; m_phase = P_OP1;
    end else if (m_phase == P_LOAD1 || m_phase == P_LOAD2) begin
      m_left--;
      if (m_left == 0) begin
        if (m_phase == P_LOAD1) begin
          m_mag = 0; m_neg = 1'b0; m_phase = P_OP2;
        end else begin
          m_phase = P_RES; m_en = 1'b1;
        end
      end
    end else if (kv) begin
      if (m_phase == P_OP1 || m_phase == P_OP2) begin
        if (k <= 9) m_mag = (m_mag * 10 + k) % 100;
        else if (k == 14) m_neg = !m_neg;
        else if (m_phase == P_OP1 && (k == 10 || k == 11)) begin
          m_opcode = (k == 11) ? 3'b010 : 3'b001;
          m_op = to_bcd(m_neg, m_mag); m_a1 = 1'b1; m_left = WAIT_CYC; m_phase = P_LOAD1;
        end else if (m_phase == P_OP2 && k == 12) begin
          m_op = to_bcd(m_neg, m_mag); m_a2 = 1'b1; m_left = WAIT_CYC; m_phase = P_LOAD2;
        end
      end else if (m_phase == P_RES) begin
        if (k <= 9) begin
          m_neg = 1'b0; m_mag = k; m_phase = P_OP1; m_en = 1'b0;
        end else if (chain && !of && (k == 10 || k == 11)) begin
          m_neg = res[8]; m_mag = int'(res[7:4]) * 10 + int'(res[3:0]);
          m_op = res; m_opcode = (k == 11) ? 3'b010 : 3'b001;
          m_a1 = 1'b1; m_left = WAIT_CYC; m_phase = P_LOAD1; m_en = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [8:0] exp_disp;
    exp_disp = (m_phase == P_RES) ? result : to_bcd(m_neg, m_mag);
    check_eq("op", 32'(op), 32'(m_op));
    check_eq("opcode", 32'(opcode), 32'(m_opcode));
    check_eq("assign_op1", 32'(assign_op1), 32'(m_a1));
    check_eq("assign_op2", 32'(assign_op2), 32'(m_a2));
    check_eq("alu_en", 32'(alu_en), 32'(m_en));
    check_eq("disp_val", 32'(disp_val), 32'(exp_disp));
    check_eq("disp_err", 32'(disp_err), 32'(o_flag && (m_phase == P_RES)));
  endtask

  task automatic step(input bit kv, input logic [4:0] kc);
    @(negedge clk);
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    model_step(kv, kc, result, o_flag);
    #1;
    compare_all();
  endtask

  task automatic press(input logic [4:0] kc);
    step(1'b1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_op"}, 32'(op), 32'h0);
    check_eq({tag, "_opcode"}, 32'(opcode), 32'h1);
    check_eq({tag, "_a1"}, 32'(assign_op1), 32'h0);
    check_eq({tag, "_a2"}, 32'(assign_op2), 32'h0);
    check_eq({tag, "_en"}, 32'(alu_en), 32'h0);
    check_eq({tag, "_disp"}, 32'(disp_val), 32'h0);
    check_eq({tag, "_err"}, 32'(disp_err), 32'h0);
  endtask

  initial begin
    nrst = 1'b0; key_valid = 1'b0; key_code = 5'd0; result = 9'h000; o_flag = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    nrst = 1'b1;

    // 4,7,add,1,2,eq
    press(5'd4); press(5'd7); press(5'd10);
    check_eq("t1_a1", 32'(assign_op1), 32'h1);
    check_eq("t1_op1", 32'(op), 32'h047);
    check_eq("t1_opc", 32'(opcode), 32'h1);
    idle(1);
    check_eq("t1_hold1", 32'(op), 32'h047);
    idle(1);
    press(5'd1); press(5'd2); press(5'd12);
    check_eq("t1_a2", 32'(assign_op2), 32'h1);
    check_eq("t1_op2", 32'(op), 32'h012);
    idle(1);
    check_eq("t1_hold2", 32'(op), 32'h012);
    idle(1);
    check_eq("t1_en", 32'(alu_en), 32'h1);

    // 3,neg,sub,5,eq starting from RESULT
    press(5'd3); press(5'd14); press(5'd11);
    check_eq("t2_op1", 32'(op), 32'h103);
    check_eq("t2_opc", 32'(opcode), 32'h2);
    idle(2);
    press(5'd5); press(5'd12);
    check_eq("t2_op2", 32'(op), 32'h005);
    idle(2);

    // three digits drop the oldest; double negate restores
    press(5'd13); press(5'd1); press(5'd2); press(5'd3);
    check_eq("t3_disp", 32'(disp_val), 32'h023);
    press(5'd14); press(5'd14);
    check_eq("t3_negneg", 32'(disp_val), 32'h023);

    // key dropped in LOAD1, clear during LOAD2
    press(5'd10); press(5'd6); idle(1);
    check_eq("t4_drop", 32'(disp_val), 32'h000);
    press(5'd12); press(5'd13);
    check_eq("t4_clr_en", 32'(alu_en), 32'h0);
    check_eq("t4_clr_opc", 32'(opcode), 32'h1);

    // add/sub in RESULT with and without overflow
    result = 9'h059; o_flag = 1'b1;
    press(5'd1); press(5'd10); idle(2); press(5'd2); press(5'd12); idle(2);
    check_eq("t5_en", 32'(alu_en), 32'h1);
    check_eq("t5_err", 32'(disp_err), 32'h1);
    check_eq("t5_disp", 32'(disp_val), 32'h059);
    press(5'd10);
    check_eq("t5_ovf_ign", 32'(assign_op1), 32'h0);
    o_flag = 1'b0;
    press(5'd10);
`ifdef OPERAND_CHAIN_EN
    check_eq("t5_chain_a1", 32'(assign_op1), 32'h1);
    check_eq("t5_chain_op", 32'(op), 32'h059);
`else
    check_eq("t5_nochain_a1", 32'(assign_op1), 32'h0);
`endif

    // asynchronous reset during the assign_op2 pulse
    press(5'd13); press(5'd9); press(5'd11); idle(2); press(5'd4); press(5'd12);
    check_eq("t6_a2", 32'(assign_op2), 32'h1);
    check_eq("t6_op", 32'(op), 32'h004);
    nrst = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    model_reset();
    @(negedge clk);
    key_valid = 1'b0;
    nrst = 1'b1;
    press(5'd10);
    check_eq("t6_post_a1", 32'(assign_op1), 32'h1);
    check_eq("t6_post_op", 32'(op), 32'h000);

    // randomized keys against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 9) == 0) begin
        result = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        o_flag = 1'($urandom_range(0, 1));
      end
      r = int'($urandom_range(0, 99));
      if (r < 40)      press(5'($urandom_range(0, 9)));
      else if (r < 50) press(5'($urandom_range(10, 11)));
      else if (r < 58) press(5'd12);
      else if (r < 60) press(5'd13);
      else if (r < 66) press(5'd14);
      else if (r < 70) press(5'($urandom_range(15, 31)));
      else             idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
